// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding for the serial adder sequencer
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand and result valid/ready bundle of the serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport slave (input in_valid, a_in, b_in, out_ready, output in_ready, out_valid, sum, cout, busy);
  modport master (output in_valid, a_in, b_in, out_ready, input in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/serial_add_ctrl_dp.sv
// serial_add_dp: operand/result shift registers, full adder and carry flop, LSB first
module serial_add_dp #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_d_o,
  output logic             carry_d_o
);
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             c_q, s;
  assign s         = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_d_o = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  // each sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB
  assign res_d_o   = {s, r_q[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= 1'b0;
    end else if (load_i) begin
      a_q <= a_i;
      b_q <= b_i;
      r_q <= '0;
      c_q <= 1'b0;
    end else if (shift_i) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      r_q <= res_d_o;
      c_q <= carry_d_o;
    end
  end
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for a bit-serial adder with valid/ready operand and result handshakes
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(parameter int WIDTH = 8) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q, res_d;
  logic             cout_q, carry_d, load, shift, last;
  assign load  = state_q == IDLE && bus.in_valid;
  assign shift = state_q == SHIFT;
  assign last  = shift && cnt_q == CW'(WIDTH - 1);
  serial_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .shift_i   (shift),
    .a_i       (bus.a_in),
    .b_i       (bus.b_in),
    .res_d_o   (res_d),
    .carry_d_o (carry_d)
  );
  // result is captured on the final shift so sum/cout stay frozen while the next job shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
        end
        SHIFT: begin
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            sum_q   <= res_d;
            cout_q  <= carry_d;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q == SHIFT;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the serial adder at WIDTH 8 and 5
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serial_add_ctrl_if #(.WIDTH(8)) b8 ();
  serial_add_ctrl_if #(.WIDTH(5)) b5 ();
  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  serial_add_ctrl #(.WIDTH(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
  int n_cmp = 0;
  int n_err = 0;
  int got8 = 0;
  int got5 = 0;
  logic [8:0] q8[$];
  logic [5:0] q5[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q5.delete();
    end else begin
      if (b8.in_valid && b8.in_ready) q8.push_back({1'b0, b8.a_in} + {1'b0, b8.b_in});
      if (b5.in_valid && b5.in_ready) q5.push_back({1'b0, b5.a_in} + {1'b0, b5.b_in});
      if (b8.out_valid && b8.out_ready) begin
        chk("sb8_nonempty", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) chk("sb8_result", 32'({b8.cout, b8.sum}), 32'(q8.pop_front()));
        got8++;
      end
      if (b5.out_valid && b5.out_ready) begin
        chk("sb5_nonempty", 32'(q5.size() != 0), 1);
        if (q5.size() != 0) chk("sb5_result", 32'({b5.cout, b5.sum}), 32'(q5.pop_front()));
        got5++;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input bit hold);
    chk("in_ready_idle", 32'(b8.in_ready), 1);
    b8.a_in = a;
    b8.b_in = b;
    b8.in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) b8.in_valid = 1'b0;
    chk("busy_after_accept", 32'(b8.busy), 1);
    chk("in_ready_shift", 32'(b8.in_ready), 0);
  endtask
  task automatic wait_done8(input bit scramble, output int lat);
    lat = 0;
    while (!b8.out_valid && lat < 40) begin
      if (scramble) begin
        b8.a_in = 8'($urandom);
        b8.b_in = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s, input logic c);
    int lat;
    start8(a, b, 1'b0);
    wait_done8(1'b0, lat);
    chk("latency", 32'(lat), 8);
    chk("sum", 32'(b8.sum), 32'(s));
    chk("cout", 32'(b8.cout), 32'(c));
  endtask
  initial begin
    int lat, t, base, quiet;
    b8.in_valid = 1'b0; b8.a_in = '0; b8.b_in = '0; b8.out_ready = 1'b0;
    b5.in_valid = 1'b0; b5.a_in = '0; b5.b_in = '0; b5.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(b8.in_ready), 1);
    chk("rst_out_valid", 32'(b8.out_valid), 0);
    chk("rst_busy", 32'(b8.busy), 0);
    chk("rst_sum", 32'(b8.sum), 0);
    chk("rst_cout", 32'(b8.cout), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    b8.out_ready = 1'b1;
    run8(8'd45, 8'd35, 8'd80, 1'b0);
    @(posedge clk); #1;
    chk("pulse_out_valid", 32'(b8.out_valid), 0);
    chk("pulse_in_ready", 32'(b8.in_ready), 1);
    chk("idle_sum_hold", 32'(b8.sum), 80);
    run8(8'd90, 8'd110, 8'd200, 1'b0);
    @(posedge clk); #1;
    run8(8'd255, 8'd1, 8'd0, 1'b1);
    @(posedge clk); #1;
    run8(8'd255, 8'd255, 8'd254, 1'b1);
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    run8(8'd100, 8'd27, 8'd127, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(b8.out_valid), 1);
      chk("bp_sum", 32'(b8.sum), 127);
      chk("bp_in_ready", 32'(b8.in_ready), 0);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'(b8.in_ready), 1);
    chk("bp_release_valid", 32'(b8.out_valid), 0);
    start8(8'd20, 8'd30, 1'b1);
    wait_done8(1'b1, lat);
    chk("scramble_latency", 32'(lat), 8);
    chk("scramble_sum", 32'(b8.sum), 50);
    chk("scramble_cout", 32'(b8.cout), 0);
    b8.a_in = 8'd200;
    b8.b_in = 8'd100;
    @(posedge clk); #1;
    chk("idle_visited", 32'(b8.in_ready), 1);
    chk("idle_busy", 32'(b8.busy), 0);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    chk("second_accept", 32'(b8.busy), 1);
    wait_done8(1'b0, lat);
    chk("second_sum", 32'(b8.sum), 44);
    chk("second_cout", 32'(b8.cout), 1);
    @(posedge clk); #1;
    start8(8'd99, 8'd99, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(b8.in_ready), 1);
    chk("arst_out_valid", 32'(b8.out_valid), 0);
    chk("arst_busy", 32'(b8.busy), 0);
    chk("arst_sum", 32'(b8.sum), 0);
    chk("arst_cout", 32'(b8.cout), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b8.out_valid) quiet++;
    end
    chk("aborted_no_valid", 32'(quiet), 0);
    run8(8'd12, 8'd7, 8'd19, 1'b0);
    @(posedge clk); #1;
    base = got8;
    for (int i = 0; i < 200; i++) begin
      b8.a_in = 8'($urandom);
      b8.b_in = 8'($urandom);
      b8.in_valid = 1'b1;
      t = 0;
      while (!b8.in_ready && t < 100) begin
        b8.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        t++;
      end
      chk("rand8_accept_bound", 32'(t < 100), 1);
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      b8.out_ready = 1'($urandom_range(0, 1));
    end
    b8.out_ready = 1'b1;
    t = 0;
    while ((q8.size() != 0 || b8.out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rand8_drained", 32'(q8.size()), 0);
    chk("rand8_count", 32'(got8 - base), 200);
    base = got5;
    for (int i = 0; i < 200; i++) begin
      b5.a_in = 5'($urandom);
      b5.b_in = 5'($urandom);
      b5.in_valid = 1'b1;
      t = 0;
      while (!b5.in_ready && t < 100) begin
        b5.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        t++;
      end
      chk("rand5_accept_bound", 32'(t < 100), 1);
      @(posedge clk); #1;
      b5.in_valid = 1'b0;
      b5.out_ready = 1'($urandom_range(0, 1));
    end
    b5.out_ready = 1'b1;
    t = 0;
    while ((q5.size() != 0 || b5.out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rand5_drained", 32'(q5.size()), 0);
    chk("rand5_count", 32'(got5 - base), 200);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
